// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared definitions for the two-port memory arbiter:
//   - default address/data widths
//   - FSM state encoding (IDLE, ACCESS, RESP)
//   - requester-ID encoding (IF = 0, DM = 1)
//   - otherPort(): helper that returns the opposite requester
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arbState_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } reqId_t;

  function automatic reqId_t otherPort(input reqId_t id);
    return (id == REQ_IF) ? REQ_DM : REQ_IF;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Arbitrates an instruction-fetch port and a data port onto one
// single-port synchronous memory. One access is in flight at a time:
// IDLE (arbitrate + register mem_*), ACCESS (grant, write strobe),
// RESP (read data returned). Reads return rvalid two cycles after the
// request is sampled in IDLE.
//
// Configuration macro: MEM_ARB_RR_EN
//   defined   -> round-robin between the ports on simultaneous requests
//   undefined -> fixed priority, data port over fetch port
//
// Ports:
//   clk_org, reset            clock, synchronous active-high reset
//   if_req/if_addr            fetch request and address
//   if_gnt/if_rvalid/if_rdata fetch grant pulse, data-valid pulse, data
//   dm_req/dm_we/dm_addr/dm_wdata  data request, store flag, addr, data
//   dm_gnt/dm_rvalid/dm_rdata data grant pulse, data-valid pulse, data
//   mem_addr/mem_wdata/mem_we registered drive to the memory
//   mem_rdata                 memory read data (one cycle after addr)
//   busy                      high whenever the FSM is not in IDLE
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_org,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arbState_t         r_state;
  arbState_t         w_nextState;
  reqId_t            r_winner;
  logic              r_isStore;
  logic [ADDR_W-1:0] r_memAddr;
  logic [DATA_W-1:0] r_memWdata;
  logic              r_memWe;
  logic [DATA_W-1:0] r_ifRdata;
  logic [DATA_W-1:0] r_dmRdata;
  logic              w_anyReq;
  reqId_t            w_pick;

  assign w_anyReq = if_req | dm_req;

`ifdef MEM_ARB_RR_EN
  // r_rrPtr names the port that wins the next tie; it flips to the
  // other port each time a grant is issued.
  reqId_t r_rrPtr;

  always_comb begin
    w_pick = REQ_IF;
    if (if_req && dm_req) begin
      w_pick = r_rrPtr;
    end else if (dm_req) begin
      w_pick = REQ_DM;
    end
  end

  always_ff @(posedge clk_org) begin
    if (reset) begin
      r_rrPtr <= REQ_IF;
    end else if (r_state == ST_ACCESS) begin
      r_rrPtr <= otherPort(r_winner);
    end
  end
`else
  // Fixed priority: the data port always wins a tie.
  always_comb begin
    w_pick = dm_req ? REQ_DM : REQ_IF;
  end
`endif

  // State register.
  always_ff @(posedge clk_org) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: stores finish after ACCESS, reads go on to RESP.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:   if (w_anyReq) w_nextState = ST_ACCESS;
      ST_ACCESS: w_nextState = r_isStore ? ST_IDLE : ST_RESP;
      ST_RESP:   w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  // Capture the winner's request at arbitration. The write strobe is
  // set only for a data-port store and drops again after ACCESS.
  always_ff @(posedge clk_org) begin
    if (reset) begin
      r_winner   <= REQ_IF;
      r_isStore  <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_memWe    <= 1'b0;
    end else begin
      r_memWe <= 1'b0;
      if (r_state == ST_IDLE && w_anyReq) begin
        r_winner <= w_pick;
        if (w_pick == REQ_DM) begin
          r_memAddr  <= dm_addr;
          r_memWdata <= dm_wdata;
          r_isStore  <= dm_we;
          r_memWe    <= dm_we;
        end else begin
          r_memAddr <= if_addr;
          r_isStore <= 1'b0;
        end
      end
    end
  end

  // Hold each port's last read word between rvalid pulses.
  always_ff @(posedge clk_org) begin
    if (reset) begin
      r_ifRdata <= '0;
      r_dmRdata <= '0;
    end else if (r_state == ST_RESP) begin
      if (r_winner == REQ_DM) begin
        r_dmRdata <= mem_rdata;
      end else begin
        r_ifRdata <= mem_rdata;
      end
    end
  end

  // Output decode. Pulses are masked while reset is asserted so an
  // access that is being aborted never reports a grant or data.
  always_comb begin
    if_gnt    = 1'b0;
    if_rvalid = 1'b0;
    dm_gnt    = 1'b0;
    dm_rvalid = 1'b0;
    if_rdata  = r_ifRdata;
    dm_rdata  = r_dmRdata;
    busy      = (r_state != ST_IDLE);
    if (!reset) begin
      case (r_state)
        ST_ACCESS: begin
          if (r_winner == REQ_DM) dm_gnt = 1'b1;
          else                    if_gnt = 1'b1;
        end
        ST_RESP: begin
          if (r_winner == REQ_DM) begin
            dm_rvalid = 1'b1;
            dm_rdata  = mem_rdata;
          end else begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;
  assign mem_we    = r_memWe;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter with a behavioural synchronous
// single-port memory. Builds for either arbitration mode
// (MEM_ARB_RR_EN defined or not).
module tb_mem_arbiter;

  logic        clk_org;
  logic        reset;
  logic        ifReq;
  logic [15:0] ifAddr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        dmReq, dmWe;
  logic [15:0] dmAddr;
  logic [31:0] dmWdata;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] memRdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] IFD = 32'h02010007;
  localparam logic [31:0] DB  = 32'hDEADBEEF;

  mem_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
    .clk_org   (clk_org),
    .reset     (reset),
    .if_req    (ifReq),
    .if_addr   (ifAddr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dmReq),
    .dm_we     (dmWe),
    .dm_addr   (dmAddr),
    .dm_wdata  (dmWdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (memRdata),
    .busy      (busy)
  );

  initial clk_org = 1'b0;
  always #5 clk_org = ~clk_org;

  // Memory model: pattern-filled on reset, word 5 holds the fetch word.
  logic [31:0] memArr [0:255];
  always @(posedge clk_org) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) memArr[i] <= 32'hC0DE0000 | 32'(i);
      memArr[5] <= IFD;
    end else begin
      if (mem_we) memArr[mem_addr[7:0]] <= mem_wdata;
      memRdata <= memArr[mem_addr[7:0]];
    end
  end

  typedef struct {
    logic        rst;
    logic        ifReq;
    logic [15:0] ifAddr;
    logic        dmReq;
    logic        dmWe;
    logic [15:0] dmAddr;
    logic [31:0] dmWdata;
    logic        eIfGnt;
    logic        eIfRv;
    logic [31:0] eIfRd;
    logic        eDmGnt;
    logic        eDmRv;
    logic [31:0] eDmRd;
    logic        eMemWe;
    logic [15:0] eMemAddr;
    logic        eBusy;
  } vec_t;

  function automatic vec_t mkVec(
    logic rst, logic iq, logic [15:0] ia, logic dq, logic dw,
    logic [15:0] da, logic [31:0] dd,
    logic eig, logic eiv, logic [31:0] eid,
    logic edg, logic edv, logic [31:0] edd,
    logic emw, logic [15:0] ema, logic eb);
    vec_t v;
    v.rst = rst; v.ifReq = iq; v.ifAddr = ia; v.dmReq = dq; v.dmWe = dw;
    v.dmAddr = da; v.dmWdata = dd;
    v.eIfGnt = eig; v.eIfRv = eiv; v.eIfRd = eid;
    v.eDmGnt = edg; v.eDmRv = edv; v.eDmRd = edd;
    v.eMemWe = emw; v.eMemAddr = ema; v.eBusy = eb;
    return v;
  endfunction

  task automatic nextCycle();
    @(posedge clk_org);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    reset   = v.rst;
    ifReq   = v.ifReq;
    ifAddr  = v.ifAddr;
    dmReq   = v.dmReq;
    dmWe    = v.dmWe;
    dmAddr  = v.dmAddr;
    dmWdata = v.dmWdata;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Steps until either grant appears, bounded to a few cycles.
  task automatic waitGnt(output logic gotIf, output logic gotDm);
    int n;
    n = 0;
    while (!(if_gnt || dm_gnt) && n < 8) begin
      nextCycle();
      #1;
      n++;
    end
    gotIf = if_gnt;
    gotDm = dm_gnt;
    if (!(gotIf || gotDm)) begin
      checks++;
      errors++;
      $display("[TB] FAIL gnt timeout: got no grant expected a grant within 8 cycles");
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  vec_t vecs[13];
  logic gi, gd, expDm;

  initial begin
    reset = 1'b1; ifReq = 1'b0; ifAddr = '0;
    dmReq = 1'b0; dmWe = 1'b0; dmAddr = '0; dmWdata = '0;

    // Cycle-by-cycle table: reset, single fetch, store then load.
    vecs[0]  = mkVec(1, 0, 16'h0,  0, 0, 16'h0,  32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 16'h0,  0);
    vecs[1]  = mkVec(1, 0, 16'h0,  0, 0, 16'h0,  32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 16'h0,  0);
    vecs[2]  = mkVec(0, 1, 16'h5,  0, 0, 16'h0,  32'h0, 0, 0, 32'h0, 0, 0, 32'h0, 0, 16'h0,  0);
    vecs[3]  = mkVec(0, 1, 16'h5,  0, 0, 16'h0,  32'h0, 1, 0, 32'h0, 0, 0, 32'h0, 0, 16'h5,  1);
    vecs[4]  = mkVec(0, 0, 16'h0,  0, 0, 16'h0,  32'h0, 0, 1, IFD,   0, 0, 32'h0, 0, 16'h5,  1);
    vecs[5]  = mkVec(0, 0, 16'h0,  0, 0, 16'h0,  32'h0, 0, 0, IFD,   0, 0, 32'h0, 0, 16'h5,  0);
    vecs[6]  = mkVec(0, 0, 16'h0,  1, 1, 16'h10, DB,    0, 0, IFD,   0, 0, 32'h0, 0, 16'h5,  0);
    vecs[7]  = mkVec(0, 0, 16'h0,  1, 1, 16'h10, DB,    0, 0, IFD,   1, 0, 32'h0, 1, 16'h10, 1);
    vecs[8]  = mkVec(0, 0, 16'h0,  0, 0, 16'h0,  32'h0, 0, 0, IFD,   0, 0, 32'h0, 0, 16'h10, 0);
    vecs[9]  = mkVec(0, 0, 16'h0,  1, 0, 16'h10, 32'h0, 0, 0, IFD,   0, 0, 32'h0, 0, 16'h10, 0);
    vecs[10] = mkVec(0, 0, 16'h0,  1, 0, 16'h10, 32'h0, 0, 0, IFD,   1, 0, 32'h0, 0, 16'h10, 1);
    vecs[11] = mkVec(0, 0, 16'h0,  0, 0, 16'h0,  32'h0, 0, 0, IFD,   0, 1, DB,    0, 16'h10, 1);
    vecs[12] = mkVec(0, 0, 16'h0,  0, 0, 16'h0,  32'h0, 0, 0, IFD,   0, 0, DB,    0, 16'h10, 0);

    for (int k = 0; k < 13; k++) begin
      nextCycle();
      applyStimulus(vecs[k]);
      #1;
      checkOutput($sformatf("row%0d if_gnt", k),    32'(if_gnt),    32'(vecs[k].eIfGnt));
      checkOutput($sformatf("row%0d if_rvalid", k), 32'(if_rvalid), 32'(vecs[k].eIfRv));
      checkOutput($sformatf("row%0d if_rdata", k),  if_rdata,       vecs[k].eIfRd);
      checkOutput($sformatf("row%0d dm_gnt", k),    32'(dm_gnt),    32'(vecs[k].eDmGnt));
      checkOutput($sformatf("row%0d dm_rvalid", k), 32'(dm_rvalid), 32'(vecs[k].eDmRv));
      checkOutput($sformatf("row%0d dm_rdata", k),  dm_rdata,       vecs[k].eDmRd);
      checkOutput($sformatf("row%0d mem_we", k),    32'(mem_we),    32'(vecs[k].eMemWe));
      checkOutput($sformatf("row%0d mem_addr", k),  32'(mem_addr),  32'(vecs[k].eMemAddr));
      checkOutput($sformatf("row%0d busy", k),      32'(busy),      32'(vecs[k].eBusy));
    end

    // Simultaneous requests, four rounds. Both requests stay high; the
    // data request drops after the fourth grant.
    ifReq = 1'b1; ifAddr = 16'h21;
    dmReq = 1'b1; dmWe = 1'b0; dmAddr = 16'h22;
    #1;
    for (int r = 0; r < 4; r++) begin
`ifdef MEM_ARB_RR_EN
      expDm = (r % 2) == 1;
`else
      expDm = 1'b1;
`endif
      waitGnt(gi, gd);
      checkOutput($sformatf("arb%0d dm_gnt", r), 32'(gd), 32'(expDm));
      checkOutput($sformatf("arb%0d if_gnt", r), 32'(gi), 32'(!expDm));
      if (r == 3) dmReq = 1'b0;
      nextCycle();
      #1;
      checkOutput($sformatf("arb%0d dm_rvalid", r), 32'(dm_rvalid), 32'(expDm));
      checkOutput($sformatf("arb%0d if_rvalid", r), 32'(if_rvalid), 32'(!expDm));
      if (expDm) checkOutput($sformatf("arb%0d dm_rdata", r), dm_rdata, 32'hC0DE0022);
      else       checkOutput($sformatf("arb%0d if_rdata", r), if_rdata, 32'hC0DE0021);
    end
    waitGnt(gi, gd);
    checkOutput("arb tail if_gnt", 32'(gi), 32'd1);
    checkOutput("arb tail dm_gnt", 32'(gd), 32'd0);
    ifReq = 1'b0;
    nextCycle();
    #1;
    checkOutput("arb tail if_rvalid", 32'(if_rvalid), 32'd1);
    checkOutput("arb tail if_rdata", if_rdata, 32'hC0DE0021);
    nextCycle();
    #1;
    checkOutput("arb tail busy", 32'(busy), 32'd0);

    // Request raised during RESP waits for the following IDLE cycle.
    ifReq = 1'b1; ifAddr = 16'h7;
    nextCycle();
    #1;
    checkOutput("resp-req if_gnt", 32'(if_gnt), 32'd1);
    ifReq = 1'b0;
    nextCycle();
    dmReq = 1'b1; dmWe = 1'b0; dmAddr = 16'h8;
    #1;
    checkOutput("resp-req if_rvalid", 32'(if_rvalid), 32'd1);
    checkOutput("resp-req if_rdata", if_rdata, 32'hC0DE0007);
    checkOutput("resp-req dm_gnt in RESP", 32'(dm_gnt), 32'd0);
    nextCycle();
    #1;
    checkOutput("resp-req dm_gnt in IDLE", 32'(dm_gnt), 32'd0);
    checkOutput("resp-req busy in IDLE", 32'(busy), 32'd0);
    nextCycle();
    #1;
    checkOutput("resp-req dm_gnt T+1", 32'(dm_gnt), 32'd1);
    dmReq = 1'b0;
    nextCycle();
    #1;
    checkOutput("resp-req dm_rvalid", 32'(dm_rvalid), 32'd1);
    checkOutput("resp-req dm_rdata", dm_rdata, 32'hC0DE0008);
    nextCycle();
    #1;

    // Reset during ACCESS of a store aborts it.
    dmReq = 1'b1; dmWe = 1'b1; dmAddr = 16'h40; dmWdata = 32'h12345678;
    nextCycle();
    reset = 1'b1; dmReq = 1'b0;
    #1;
    checkOutput("abort mem_we in ACCESS", 32'(mem_we), 32'd1);
    checkOutput("abort dm_gnt in ACCESS", 32'(dm_gnt), 32'd0);
    nextCycle();
    #1;
    checkOutput("abort mem_we after", 32'(mem_we), 32'd0);
    checkOutput("abort dm_gnt after", 32'(dm_gnt), 32'd0);
    checkOutput("abort busy after", 32'(busy), 32'd0);
    checkOutput("abort mem_addr after", 32'(mem_addr), 32'd0);
    reset = 1'b0;
    nextCycle();
    #1;
    checkOutput("abort dm_gnt idle", 32'(dm_gnt), 32'd0);
    checkOutput("abort dm_rvalid idle", 32'(dm_rvalid), 32'd0);
    checkOutput("abort busy idle", 32'(busy), 32'd0);
    checkOutput("abort dm_rdata cleared", dm_rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
